// File: rtl/cfu_bus_pkg.sv
// Shared types and defaults for the two-master CFU bus arbiter.
// Owner ids identify which CfuPlugin master issued an outstanding command.
package cfu_bus_pkg;

   localparam int FID_W_DEF           = 10;
   localparam int DATA_W_DEF          = 32;
   localparam int MAX_OUTSTANDING_DEF = 4;

   typedef logic ownerId_t;

   localparam ownerId_t OWNER_M0 = 1'b0;
   localparam ownerId_t OWNER_M1 = 1'b1;

   typedef struct packed {
      logic [FID_W_DEF-1:0]  functionId;
      logic [DATA_W_DEF-1:0] inputs0;
      logic [DATA_W_DEF-1:0] inputs1;
   } cmdPayload_t;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] outputs0;
   } rspPayload_t;

   // A depth-1 FIFO still needs a 1-bit pointer to keep vector widths legal.
   function automatic int ptrWidth(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/cfu_owner_fifo.sv
// In-order FIFO of owner ids, one entry per command the CFU has accepted
// but not yet answered. Head is read combinationally for zero-latency routing.
module cfu_owner_fifo
   import cfu_bus_pkg::*;
#(
   parameter  int DEPTH = MAX_OUTSTANDING_DEF,
   localparam int PTR_W = ptrWidth(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  ownerId_t         pushOwner,
   input  logic             pop,
   output ownerId_t         headOwner,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [PTR_W-1:0] rdPtrReg;
   logic [PTR_W-1:0] wrPtrReg;
   logic [CNT_W-1:0] countReg;
   ownerId_t         storeReg [DEPTH];
   logic [DEPTH-1:0] wrEn;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wrEn
      assign wrEn[gi] = push & (wrPtrReg == PTR_W'(gi));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) storeReg[i] <= OWNER_M0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wrEn[i]) storeReg[i] <= pushOwner;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdPtrReg <= '0;
         wrPtrReg <= '0;
         countReg <= '0;
      end else begin
         if (push) wrPtrReg <= nextPtr(wrPtrReg);
         if (pop)  rdPtrReg <= nextPtr(rdPtrReg);
         case ({push, pop})
            2'b10:   countReg <= countReg + 1'b1;
            2'b01:   countReg <= countReg - 1'b1;
            default: countReg <= countReg;
         endcase
      end
   end

   assign headOwner = storeReg[rdPtrReg];
   assign full      = (countReg == CNT_W'(DEPTH));
   assign empty     = (countReg == '0);
   assign count     = countReg;

endmodule

// File: rtl/cfu_bus_arbiter.sv
// Shares one CFU between two CfuPlugin masters: round-robin command grant with
// a stall lock, and an owner FIFO that steers each response back to its issuer.
module cfu_bus_arbiter
   import cfu_bus_pkg::*;
#(
   parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
   parameter int FID_W           = FID_W_DEF,
   parameter int DATA_W          = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              m0_cmd_valid,
   output logic              m0_cmd_ready,
   input  logic [FID_W-1:0]  m0_cmd_payload_function_id,
   input  logic [DATA_W-1:0] m0_cmd_payload_inputs_0,
   input  logic [DATA_W-1:0] m0_cmd_payload_inputs_1,
   output logic              m0_rsp_valid,
   input  logic              m0_rsp_ready,
   output logic [DATA_W-1:0] m0_rsp_payload_outputs_0,

   input  logic              m1_cmd_valid,
   output logic              m1_cmd_ready,
   input  logic [FID_W-1:0]  m1_cmd_payload_function_id,
   input  logic [DATA_W-1:0] m1_cmd_payload_inputs_0,
   input  logic [DATA_W-1:0] m1_cmd_payload_inputs_1,
   output logic              m1_rsp_valid,
   input  logic              m1_rsp_ready,
   output logic [DATA_W-1:0] m1_rsp_payload_outputs_0,

   output logic              s_cmd_valid,
   input  logic              s_cmd_ready,
   output logic [FID_W-1:0]  s_cmd_payload_function_id,
   output logic [DATA_W-1:0] s_cmd_payload_inputs_0,
   output logic [DATA_W-1:0] s_cmd_payload_inputs_1,
   input  logic              s_rsp_valid,
   output logic              s_rsp_ready,
   input  logic [DATA_W-1:0] s_rsp_payload_outputs_0,

   output logic              busy
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   ownerId_t         lastGrantReg;
   logic             lockReg;
   ownerId_t         lockedOwnerReg;

   ownerId_t         sel;
   logic             selValid;
   logic             cmdFire;
   logic             rspFire;
   ownerId_t         headOwner;
   logic             full;
   logic             empty;
   logic [CNT_W-1:0] ownerCount;

   // A stalled command keeps its master selected until it fires.
   always_comb begin
      sel = OWNER_M0;
      if (lockReg)                          sel = lockedOwnerReg;
      else if (m0_cmd_valid && m1_cmd_valid) sel = ~lastGrantReg;
      else if (m1_cmd_valid)                sel = OWNER_M1;
   end

   assign selValid    = (sel == OWNER_M1) ? m1_cmd_valid : m0_cmd_valid;
   assign s_cmd_valid = selValid & ~full;
   assign cmdFire     = s_cmd_valid & s_cmd_ready;

   assign m0_cmd_ready = cmdFire & (sel == OWNER_M0);
   assign m1_cmd_ready = cmdFire & (sel == OWNER_M1);

   assign s_cmd_payload_function_id = (sel == OWNER_M1) ? m1_cmd_payload_function_id
                                                        : m0_cmd_payload_function_id;
   assign s_cmd_payload_inputs_0    = (sel == OWNER_M1) ? m1_cmd_payload_inputs_0
                                                        : m0_cmd_payload_inputs_0;
   assign s_cmd_payload_inputs_1    = (sel == OWNER_M1) ? m1_cmd_payload_inputs_1
                                                        : m0_cmd_payload_inputs_1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lastGrantReg   <= OWNER_M1;
         lockReg        <= 1'b0;
         lockedOwnerReg <= OWNER_M0;
      end else if (cmdFire) begin
         lastGrantReg <= sel;
         lockReg      <= 1'b0;
      end else if (s_cmd_valid) begin
         lockReg        <= 1'b1;
         lockedOwnerReg <= sel;
      end
   end

   // A response arriving with nothing outstanding is held off, never dropped.
   assign s_rsp_ready  = ~empty & ((headOwner == OWNER_M1) ? m1_rsp_ready : m0_rsp_ready);
   assign rspFire      = s_rsp_valid & s_rsp_ready;
   assign m0_rsp_valid = s_rsp_valid & ~empty & (headOwner == OWNER_M0);
   assign m1_rsp_valid = s_rsp_valid & ~empty & (headOwner == OWNER_M1);

   assign m0_rsp_payload_outputs_0 = s_rsp_payload_outputs_0;
   assign m1_rsp_payload_outputs_0 = s_rsp_payload_outputs_0;

   assign busy = (ownerCount != '0);

   cfu_owner_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_ownerFifo (
      .clk       (clk),
      .reset     (reset),
      .push      (cmdFire),
      .pushOwner (sel),
      .pop       (rspFire),
      .headOwner (headOwner),
      .full      (full),
      .empty     (empty),
      .count     (ownerCount)
   );

endmodule

// File: tb/tb_cfu_bus_arbiter.sv
// Directed scenarios followed by random traffic, all checked cycle by cycle
// against a queue-based model of grant order and response ownership.
module tb_cfu_bus_arbiter;
   import cfu_bus_pkg::*;

   localparam int MAXO = 4;
   localparam int FW   = 10;
   localparam int DW   = 32;

   typedef struct packed {
      logic [FW-1:0] fid;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } cmd_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          m0_cmd_valid, m0_cmd_ready, m0_rsp_valid, m0_rsp_ready;
   logic [FW-1:0] m0_cmd_payload_function_id;
   logic [DW-1:0] m0_cmd_payload_inputs_0, m0_cmd_payload_inputs_1, m0_rsp_payload_outputs_0;
   logic          m1_cmd_valid, m1_cmd_ready, m1_rsp_valid, m1_rsp_ready;
   logic [FW-1:0] m1_cmd_payload_function_id;
   logic [DW-1:0] m1_cmd_payload_inputs_0, m1_cmd_payload_inputs_1, m1_rsp_payload_outputs_0;
   logic          s_cmd_valid, s_cmd_ready, s_rsp_valid, s_rsp_ready, busy;
   logic [FW-1:0] s_cmd_payload_function_id;
   logic [DW-1:0] s_cmd_payload_inputs_0, s_cmd_payload_inputs_1, s_rsp_payload_outputs_0;

   always #5 clk = ~clk;

   cfu_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .FID_W(FW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready),
      .m0_cmd_payload_function_id(m0_cmd_payload_function_id),
      .m0_cmd_payload_inputs_0(m0_cmd_payload_inputs_0),
      .m0_cmd_payload_inputs_1(m0_cmd_payload_inputs_1),
      .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready),
      .m0_rsp_payload_outputs_0(m0_rsp_payload_outputs_0),
      .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready),
      .m1_cmd_payload_function_id(m1_cmd_payload_function_id),
      .m1_cmd_payload_inputs_0(m1_cmd_payload_inputs_0),
      .m1_cmd_payload_inputs_1(m1_cmd_payload_inputs_1),
      .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready),
      .m1_rsp_payload_outputs_0(m1_rsp_payload_outputs_0),
      .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
      .s_cmd_payload_function_id(s_cmd_payload_function_id),
      .s_cmd_payload_inputs_0(s_cmd_payload_inputs_0),
      .s_cmd_payload_inputs_1(s_cmd_payload_inputs_1),
      .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
      .s_rsp_payload_outputs_0(s_rsp_payload_outputs_0),
      .busy(busy)
   );

   int testCount = 0;
   int failCount = 0;

   // Model state: pending commands per master, outstanding owners in order,
   // expected results per master, and the bench-side CFU result queue.
   cmd_t          mq0[$], mq1[$];
   int            ownerQ[$];
   logic [DW-1:0] expQ0[$], expQ1[$], cfuQ[$];
   int            lastWinner, held;
   bit            rspHeld, cfuEn, rogue, sCmdReady;
   logic [1:0]    rr;

   int  eOff, eHead;
   bit  eFull, eSv, eCmdFire, eRspFire, eSRr, eEmpty;

   function automatic cmd_t mk(input int fid, input int a, input int b);
      cmd_t c;
      c.fid = FW'(fid);
      c.a   = DW'(a);
      c.b   = DW'(b);
      return c;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      testCount++;
      assert (obs === expv) else begin
         failCount++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic modelReset();
      mq0.delete(); mq1.delete(); ownerQ.delete();
      expQ0.delete(); expQ1.delete(); cfuQ.delete();
      lastWinner = 1; held = -1;
      rspHeld = 1'b0; cfuEn = 1'b0; rogue = 1'b0;
   endtask

   task automatic drive();
      m0_cmd_valid = (mq0.size() > 0);
      {m0_cmd_payload_function_id, m0_cmd_payload_inputs_0, m0_cmd_payload_inputs_1} =
         m0_cmd_valid ? mq0[0] : '0;
      m1_cmd_valid = (mq1.size() > 0);
      {m1_cmd_payload_function_id, m1_cmd_payload_inputs_0, m1_cmd_payload_inputs_1} =
         m1_cmd_valid ? mq1[0] : '0;
      s_cmd_ready  = sCmdReady;
      m0_rsp_ready = rr[0];
      m1_rsp_ready = rr[1];
      s_rsp_valid  = rogue || (cfuQ.size() > 0 && (cfuEn || rspHeld));
      s_rsp_payload_outputs_0 = rogue ? 32'hDEADBEEF : ((cfuQ.size() > 0) ? cfuQ[0] : '0);
   endtask

   task automatic computeAndCheck();
      cmd_t c;
      eFull = (ownerQ.size() == MAXO);
      if (held >= 0)                      eOff = held;
      else if (m0_cmd_valid && m1_cmd_valid) eOff = 1 - lastWinner;
      else if (m1_cmd_valid)              eOff = 1;
      else if (m0_cmd_valid)              eOff = 0;
      else                                eOff = -1;
      eSv      = (eOff >= 0) && !eFull;
      eCmdFire = eSv && sCmdReady;
      chk("s_cmd_valid", s_cmd_valid, eSv);
      if (eSv) begin
         c = (eOff == 1) ? mq1[0] : mq0[0];
         chk("s_cmd_fid", s_cmd_payload_function_id, c.fid);
         chk("s_cmd_in0", s_cmd_payload_inputs_0, c.a);
         chk("s_cmd_in1", s_cmd_payload_inputs_1, c.b);
      end
      chk("m0_cmd_ready", m0_cmd_ready, eCmdFire && eOff == 0);
      chk("m1_cmd_ready", m1_cmd_ready, eCmdFire && eOff == 1);
      eEmpty   = (ownerQ.size() == 0);
      eHead    = eEmpty ? -1 : ownerQ[0];
      eSRr     = !eEmpty && rr[eHead[0]];
      eRspFire = s_rsp_valid && eSRr;
      chk("s_rsp_ready", s_rsp_ready, eSRr);
      chk("m0_rsp_valid", m0_rsp_valid, s_rsp_valid && eHead == 0);
      chk("m1_rsp_valid", m1_rsp_valid, s_rsp_valid && eHead == 1);
      if (eRspFire && eHead == 0) chk("m0_rsp_data", m0_rsp_payload_outputs_0, expQ0[0]);
      if (eRspFire && eHead == 1) chk("m1_rsp_data", m1_rsp_payload_outputs_0, expQ1[0]);
      chk("busy", busy, !eEmpty);
   endtask

   task automatic update();
      cmd_t          c;
      logic [DW-1:0] r;
      if (eCmdFire) begin
         c = (eOff == 1) ? mq1.pop_front() : mq0.pop_front();
         r = c.a + c.b;
         ownerQ.push_back(eOff);
         if (eOff == 1) expQ1.push_back(r); else expQ0.push_back(r);
         cfuQ.push_back(r);
         lastWinner = eOff;
         held = -1;
      end else if (eSv) begin
         held = eOff;
      end
      if (eRspFire) begin
         void'(ownerQ.pop_front());
         if (eHead == 1) void'(expQ1.pop_front()); else void'(expQ0.pop_front());
         void'(cfuQ.pop_front());
         rspHeld = 1'b0;
      end else begin
         rspHeld = s_rsp_valid && !rogue;
      end
   endtask

   task automatic step();
      drive();
      #3;
      computeAndCheck();
      @(posedge clk);
      #1;
      update();
   endtask

   task automatic doReset();
      reset = 1'b1;
      modelReset();
      drive();
      #3;
      computeAndCheck();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      rr = 2'b11;
      sCmdReady = 1'b1;
      modelReset();
      drive();
      @(posedge clk);
      #1;
      doReset();

      // Single master, response two cycles after the command.
      mq0.push_back(mk(1, 3, 4));
      step(); step(); step();
      cfuEn = 1'b1;
      step(); step();

      // Contention from reset, then sustained both-valid alternation.
      doReset();
      cfuEn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mq0.push_back(mk(16 + i, i, 100));
         mq1.push_back(mk(32 + i, i, 200));
      end
      repeat (14) step();

      // Stall lock: m1 presented while the CFU stalls, m0 joins late.
      doReset();
      cfuEn = 1'b1;
      sCmdReady = 1'b0;
      mq1.push_back(mk(5, 11, 22));
      step(); step();
      mq0.push_back(mk(6, 33, 44));
      step(); step(); step();
      sCmdReady = 1'b1;
      repeat (6) step();

      // Full: five commands while the CFU withholds responses.
      doReset();
      for (int i = 0; i < 5; i++) mq0.push_back(mk(64 + i, i * 3, 7));
      repeat (7) step();
      cfuEn = 1'b1;
      repeat (8) step();

      // Ordering with m1 response backpressure: owners m1, m0, m1.
      doReset();
      mq1.push_back(mk(9, 1, 1));   step();
      mq0.push_back(mk(10, 2, 2));  step();
      mq1.push_back(mk(11, 3, 3));  step();
      rr = 2'b01;
      cfuEn = 1'b1;
      repeat (3) step();
      rr = 2'b11;
      repeat (5) step();

      // Response while nothing is outstanding must be held off.
      rogue = 1'b1;
      step();
      rogue = 1'b0;
      step();

      // Asynchronous reset with three outstanding commands.
      doReset();
      mq0.push_back(mk(1, 5, 5));
      mq1.push_back(mk(2, 6, 6));
      mq0.push_back(mk(3, 7, 7));
      repeat (5) step();
      cfuEn = 1'b1;
      drive();
      #1;
      chk("pre_reset_busy", busy, ownerQ.size() > 0);
      reset = 1'b1;
      #1;
      chk("async_busy", busy, 1'b0);
      chk("async_m0_rsp_valid", m0_rsp_valid, 1'b0);
      chk("async_m1_rsp_valid", m1_rsp_valid, 1'b0);
      chk("async_s_rsp_ready", s_rsp_ready, 1'b0);
      modelReset();
      drive();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         if (mq0.size() < 3 && $urandom_range(0, 2) == 0)
            mq0.push_back(mk($urandom_range(0, 1023), $urandom, $urandom));
         if (mq1.size() < 3 && $urandom_range(0, 2) == 0)
            mq1.push_back(mk($urandom_range(0, 1023), $urandom, $urandom));
         sCmdReady = ($urandom_range(0, 3) != 0);
         cfuEn     = ($urandom_range(0, 2) == 0);
         rr        = 2'($urandom_range(0, 3));
         step();
      end
      sCmdReady = 1'b1;
      cfuEn = 1'b1;
      rr = 2'b11;
      repeat (30) step();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/cfu_bus_arbiter.md
Name: cfu_bus_arbiter

Overview:
Shares one CFU (cmd/rsp stream bus: 10-bit function_id, two 32-bit inputs, one 32-bit output) between two CfuPlugin masters, e.g. two VexRiscv cores. Arbitrates commands round-robin and tracks owners of outstanding commands in an in-order owner FIFO, so each response returns to its issuer. Sits between the cores' CfuPlugin buses and the single Cfu instance.

Parameters:
MAX_OUTSTANDING, 4, max commands accepted by the CFU and not yet answered (power of 2, >=1)
FID_W, 10, function_id width
DATA_W, 32, operand/result width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
m0_cmd_valid / m1_cmd_valid  in  1  master command valid
m0_cmd_ready / m1_cmd_ready  out  1  master command accepted
m0_cmd_payload_function_id / m1_...  in  FID_W  function id
m0_cmd_payload_inputs_0 / m1_...  in  DATA_W  operand 0
m0_cmd_payload_inputs_1 / m1_...  in  DATA_W  operand 1
m0_rsp_valid / m1_rsp_valid  out  1  response valid to master
m0_rsp_ready / m1_rsp_ready  in  1  master ready for response
m0_rsp_payload_outputs_0 / m1_...  out  DATA_W  result to master
s_cmd_valid  out  1  command to CFU
s_cmd_ready  in  1  CFU accepts command
s_cmd_payload_function_id  out  FID_W
s_cmd_payload_inputs_0 / s_cmd_payload_inputs_1  out  DATA_W
s_rsp_valid  in  1  CFU response valid
s_rsp_ready  out  1  arbiter accepts response
s_rsp_payload_outputs_0  in  DATA_W  CFU result
busy  out  1  owner FIFO non-empty

Behaviour:
- Registered state: last_grant (reset 1, so m0 wins first tie), lock (reset 0), locked_owner (reset 0), owner FIFO storage/rd_ptr/wr_ptr/count (reset 0).
- Outputs combinational from regs + inputs; with all valids low, every valid/ready output is 0 in and after reset; busy resets to 0.
- Selection: if lock, sel = locked_owner; else if only one mN_cmd_valid, that one; if both, sel = !last_grant.
- full = (count == MAX_OUTSTANDING). s_cmd_valid = mSel_cmd_valid & !full; s_cmd payload muxed from sel.
- mSel_cmd_ready = s_cmd_ready & !full; non-selected master ready = 0.
- Command fire = s_cmd_valid & s_cmd_ready: push sel into owner FIFO, last_grant <= sel, lock <= 0.
- Stability: s_cmd_valid high and not fired -> lock <= 1, locked_owner <= sel; payload/owner must not switch until fire, even if the other master asserts.
- Full: s_cmd_valid forced 0; pending master waits; lock not set while forced low.
- Response: owner = FIFO head. s_rsp_ready = !empty & mOwner_rsp_ready; mOwner_rsp_valid = s_rsp_valid & !empty; other master rsp_valid = 0. Both masters see s_rsp_payload_outputs_0.
- Response fire = s_rsp_valid & s_rsp_ready: pop head.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance; allowed even at full only if push was permitted (full blocks push that cycle regardless of pop).
- s_rsp_valid while empty: s_rsp_ready = 0 (protocol error, response held, not dropped).
- Latency: zero-cycle pass-through both directions; no added pipeline stage.
- Pointers wrap modulo MAX_OUTSTANDING; count width clog2(MAX_OUTSTANDING)+1.
- Reset mid-operation: all state cleared immediately; Cfu shares the same reset, so no stale responses.

Decomposition:
- Package cfu_bus_pkg: FID_W/DATA_W defaults, owner id type (1 bit), cmd/rsp payload typedefs.
- One sub-module: cfu_owner_fifo (depth MAX_OUTSTANDING, width 1, push/pop/full/empty/count, async reset).

Test Plan:
- Single master: m0 sends fid=0x001, in0=3, in1=4; CFU rsp 7 after 2 cycles -> m0_rsp_valid with 7, m1_rsp_valid stays 0, busy back to 0.
- Contention: m0 and m1 valid same cycle after reset -> m0 granted first, m1 next; sustained both-valid alternates m0,m1,m0,m1.
- Stall lock: s_cmd_ready=0 for 5 cycles with m1 presented, m0 raises valid at cycle 2 -> s_cmd payload stays m1's for all 5 cycles, m1 fires first.
- Full: MAX_OUTSTANDING=4, CFU withholds rsp, 5 commands issued -> 4 accepted, 5th s_cmd_valid=0 until first response pops, then accepted same cycle.
- Ordering/backpressure: outstanding owners m1,m0,m1, m1_rsp_ready=0 for 3 cycles -> s_rsp_ready=0, head response held; results delivered m1,m0,m1 in order.
- Async reset with 3 outstanding -> count=0, busy=0, all rsp_valid=0 immediately without clock edge.
